// File: rtl/ram_sram16_bridge_pkg.sv
// Shared constants for the word RAM request interface
// and the 16-bit asynchronous SRAM bridge.
package ram_sram16_bridge_pkg;

  localparam int RAM_ADDR_BITS = 4;
  localparam int RAM_ADDR_MAX = (1 << RAM_ADDR_BITS) - 1;
  localparam int SRAM_WAIT_CYCLES = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LO_ACC = 3'd1,
    S_LO_GAP = 3'd2,
    S_HI_ACC = 3'd3,
    S_HI_GAP = 3'd4,
    S_DONE   = 3'd5
  } sram_state_e;

endpackage

// File: rtl/ram_sram16_bridge.sv
// Word RAM responder: each 32-bit request becomes two 16-bit
// accesses on the external async SRAM, low half first.
module ram_sram16_bridge
  import ram_sram16_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
  parameter int ADDR_BITS = RAM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] ram_addr,
  input  logic [3:0]           ram_byteen,
  input  logic [31:0]          ram_wrdata,
  input  logic                 ram_rden,
  input  logic                 ram_wren,
  output logic [31:0]          ram_rddata,
  output logic                 ram_busy,
  output logic                 ram_rdvalid,
  output logic                 err,
  output logic [ADDR_BITS:0]   sram_addr,
  output logic [15:0]          sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [15:0]          sram_dq_i,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_lb_n,
  output logic                 sram_ub_n
);

  localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);

  sram_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] buf_q, buf_d;
  logic        err_q, err_d;

  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        rdv_q, rdv_d;
  logic [ADDR_BITS:0] saddr_q, saddr_d;
  logic [15:0] dqo_q, dqo_d;
  logic        dqoe_q, dqoe_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_q, we_d;
  logic        lb_q, lb_d;
  logic        ub_q, ub_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    be_d    = be_q;
    buf_d   = buf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (ram_rden | ram_wren) begin
          state_d = S_LO_ACC;
          cnt_d   = 3'd0;
          wr_d    = ram_wren;
          addr_d  = ram_addr;
          wdat_d  = ram_wrdata;
          be_d    = ram_byteen;
          err_d   = err_q | (ram_rden & ram_wren);
        end
      end
      S_LO_ACC: begin
        if (cnt_q == WAIT_C) begin
          cnt_d   = 3'd0;
          state_d = S_LO_GAP;
          if (!wr_q) buf_d[15:0] = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_LO_GAP: state_d = S_HI_ACC;
      S_HI_ACC: begin
        if (cnt_q == WAIT_C) begin
          cnt_d   = 3'd0;
          state_d = S_HI_GAP;
          if (!wr_q) buf_d[31:16] = sram_dq_i;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HI_GAP: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Pad strobes are decoded from the next state so they leave flops
  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    dqoe_d  = 1'b0;
    dqo_d   = dqo_q;
    saddr_d = saddr_q;
    rdv_d   = 1'b0;
    rdata_d = rdata_q;
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_LO_ACC: begin
        ce_d    = 1'b0;
        saddr_d = {addr_d, 1'b0};
        if (wr_d) begin
          we_d   = 1'b0;
          dqoe_d = 1'b1;
          dqo_d  = wdat_d[15:0];
          lb_d   = ~be_d[0];
          ub_d   = ~be_d[1];
        end else begin
          oe_d = 1'b0;
          lb_d = 1'b0;
          ub_d = 1'b0;
        end
      end
      S_HI_ACC: begin
        ce_d    = 1'b0;
        saddr_d = {addr_d, 1'b1};
        if (wr_d) begin
          we_d   = 1'b0;
          dqoe_d = 1'b1;
          dqo_d  = wdat_d[31:16];
          lb_d   = ~be_d[2];
          ub_d   = ~be_d[3];
        end else begin
          oe_d = 1'b0;
          lb_d = 1'b0;
          ub_d = 1'b0;
        end
      end
      S_LO_GAP, S_HI_GAP: dqoe_d = wr_d;
      S_DONE: begin
        if (!wr_d) begin
          rdv_d   = 1'b1;
          rdata_d = buf_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= 32'd0;
      be_q    <= 4'd0;
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
      rdv_q   <= 1'b0;
      saddr_q <= '0;
      dqo_q   <= 16'd0;
      dqoe_q  <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      lb_q    <= 1'b1;
      ub_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      be_q    <= be_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      rdv_q   <= rdv_d;
      saddr_q <= saddr_d;
      dqo_q   <= dqo_d;
      dqoe_q  <= dqoe_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      lb_q    <= lb_d;
      ub_q    <= ub_d;
    end
  end

  assign ram_rddata  = rdata_q;
  assign ram_busy    = busy_q;
  assign ram_rdvalid = rdv_q;
  assign err         = err_q;
  assign sram_addr   = saddr_q;
  assign sram_dq_o   = dqo_q;
  assign sram_dq_oe  = dqoe_q;
  assign sram_ce_n   = ce_q;
  assign sram_oe_n   = oe_q;
  assign sram_we_n   = we_q;
  assign sram_lb_n   = lb_q;
  assign sram_ub_n   = ub_q;

endmodule

// File: tb/tb_ram_sram16_bridge.sv
// Directed bench for ram_sram16_bridge with a behavioural
// 16-bit async SRAM on the pad side.
module tb_ram_sram16_bridge;
  import ram_sram16_bridge_pkg::*;

  localparam int AB = RAM_ADDR_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic [AB-1:0] ram_addr;
  logic [3:0]    ram_byteen;
  logic [31:0]   ram_wrdata;
  logic          ram_rden;
  logic          ram_wren;
  logic [31:0]   ram_rddata;
  logic          ram_busy;
  logic          ram_rdvalid;
  logic          err;
  logic [AB:0]   sram_addr;
  logic [15:0]   sram_dq_o;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_i;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_lb_n;
  logic          sram_ub_n;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:(2**(AB+1))-1];
  int we_c [2];
  int lb_c [2];
  int ub_c [2];

  ram_sram16_bridge dut (
    .clk(clk), .rst(rst),
    .ram_addr(ram_addr), .ram_byteen(ram_byteen),
    .ram_wrdata(ram_wrdata), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_rddata(ram_rddata),
    .ram_busy(ram_busy), .ram_rdvalid(ram_rdvalid),
    .err(err), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n)
                   ? mem[sram_addr] : 16'hbeef;

  initial begin
    for (int i = 0; i < 2**(AB+1); i++) mem[i] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      we_c[i] = 0;
      lb_c[i] = 0;
      ub_c[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && !sram_ce_n && !sram_we_n) begin
      we_c[sram_addr[0]] <= we_c[sram_addr[0]] + 1;
      if (!sram_lb_n) begin
        lb_c[sram_addr[0]] <= lb_c[sram_addr[0]] + 1;
        mem[sram_addr][7:0] <= sram_dq_o[7:0];
      end
      if (!sram_ub_n) begin
        ub_c[sram_addr[0]] <= ub_c[sram_addr[0]] + 1;
        mem[sram_addr][15:8] <= sram_dq_o[15:8];
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int lat, nbusy, nrdv;
  int w0, w1, l0, l1, u0, u1;
  logic [31:0] rdat;

  task automatic req(input logic wr, input logic rd,
                     input logic [AB-1:0] a,
                     input logic [31:0] d,
                     input logic [3:0] be);
    bit seen;
    bit done;
    @(negedge clk);
    w0 = we_c[0]; w1 = we_c[1];
    l0 = lb_c[0]; l1 = lb_c[1];
    u0 = ub_c[0]; u1 = ub_c[1];
    ram_addr = a;
    ram_wrdata = d;
    ram_byteen = be;
    ram_wren = wr;
    ram_rden = rd;
    lat = -1; nbusy = 0; nrdv = 0; rdat = 32'hx;
    seen = 0; done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (ram_busy) begin
        seen = 1;
        nbusy++;
      end
      if (ram_rdvalid) begin
        nrdv++;
        lat = c;
        rdat = ram_rddata;
      end
      if (seen && !ram_busy) done = 1;
    end
    ram_wren = 1'b0;
    ram_rden = 1'b0;
    if (!done) check("timeout", 32'd0, 32'd1);
    w0 = we_c[0] - w0; w1 = we_c[1] - w1;
    l0 = lb_c[0] - l0; l1 = lb_c[1] - l1;
    u0 = ub_c[0] - u0; u1 = ub_c[1] - u1;
  endtask

  initial begin
    rst = 1'b1;
    ram_addr = '0;
    ram_byteen = 4'h0;
    ram_wrdata = 32'd0;
    ram_rden = 1'b0;
    ram_wren = 1'b0;
    #1;
    check("rst_busy", 32'(ram_busy), 32'd0);
    check("rst_rdv", 32'(ram_rdvalid), 32'd0);
    check("rst_rdata", ram_rddata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_strb",
          {27'd0, sram_ce_n, sram_oe_n, sram_we_n,
           sram_lb_n, sram_ub_n}, 32'h1f);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_saddr", 32'(sram_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    req(1, 0, 4'd5, 32'hdead0005, 4'hf);
    check("w_lo_mem", 32'(mem[10]), 32'h0005);
    check("w_hi_mem", 32'(mem[11]), 32'hdead);
    check("w_we_lo", 32'(w0), 32'd2);
    check("w_we_hi", 32'(w1), 32'd2);
    check("w_busy", 32'(nbusy), 32'd7);
    check("w_rdv", 32'(nrdv), 32'd0);

    req(0, 1, 4'd5, 32'd0, 4'hf);
    check("r_lat", 32'(lat), 32'd7);
    check("r_rdv", 32'(nrdv), 32'd1);
    check("r_data", rdat, 32'hdead0005);
    check("r_busy", 32'(nbusy), 32'd7);
    repeat (3) @(negedge clk);
    check("r_hold", ram_rddata, 32'hdead0005);

    req(1, 0, 4'd3, 32'h11223344, 4'b0100);
    check("be_lb_lo", 32'(l0), 32'd0);
    check("be_ub_lo", 32'(u0), 32'd0);
    check("be_lb_hi", 32'(l1), 32'd2);
    check("be_ub_hi", 32'(u1), 32'd0);
    check("be_hold", ram_rddata, 32'hdead0005);
    req(0, 1, 4'd3, 32'd0, 4'hf);
    check("be_rd", rdat, 32'h00220000);

    req(1, 1, 4'd2, 32'hcafef00d, 4'hf);
    check("both_err", 32'(err), 32'd1);
    check("both_rdv", 32'(nrdv), 32'd0);
    req(0, 1, 4'd2, 32'd0, 4'hf);
    check("both_rd", rdat, 32'hcafef00d);
    check("err_stky", 32'(err), 32'd1);

    @(negedge clk);
    ram_addr = 4'd1;
    ram_wrdata = 32'h5555aaaa;
    ram_byteen = 4'hf;
    ram_wren = 1'b1;
    @(negedge clk);
    ram_wren = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!sram_ce_n && sram_addr[0]) break;
      @(negedge clk);
    end
    check("pre_hi", {31'd0, sram_addr[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_we", 32'(sram_we_n), 32'd1);
    check("mid_oe", 32'(sram_dq_oe), 32'd0);
    check("mid_busy", 32'(ram_busy), 32'd0);
    check("mid_rdata", ram_rddata, 32'd0);
    check("mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req(1, 0, 4'd6, 32'h0badf00d, 4'hf);
    req(0, 1, 4'd6, 32'd0, 4'hf);
    check("post_rd", rdat, 32'h0badf00d);
    check("post_lat", 32'(lat), 32'd7);

    for (int a = 0; a <= RAM_ADDR_MAX; a++)
      req(1, 0, AB'(a), 32'hdead0000 + 32'(a), 4'hf);
    for (int a = 0; a <= RAM_ADDR_MAX; a++) begin
      req(0, 1, AB'(a), 32'd0, 4'hf);
      check($sformatf("sw_%0d", a), rdat,
            32'hdead0000 + 32'(a));
    end
    check("sw_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_sram16_bridge.md
Name: ram_sram16_bridge

Overview:
- Responder end of the 32-bit word RAM request interface (addr/byteen/wrdata/rden/wren/rddata) that the init and load engines drive.
- Services each word request as two 16-bit accesses on the board's external asynchronous SRAM: low halfword first, then high.
- Provides fixed, deterministic latency, plus busy/rdvalid so requesters can use a handshake instead of blind wait counters.

Parameters:
- WAIT_CYCLES, 1, extra cycles each SRAM strobe is held beyond the minimum 1 cycle (0..7).
- ADDR_BITS, `RAM_ADDR_BITS, word address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ram_addr  in  ADDR_BITS  word address
- ram_byteen  in  4  byte enables; bit0 = bits 7:0
- ram_wrdata  in  32  write data
- ram_rden  in  1  read request (level, sampled only when idle)
- ram_wren  in  1  write request (level, sampled only when idle)
- ram_rddata  out  32  last completed read word
- ram_busy  out  1  high while a request is in flight
- ram_rdvalid  out  1  one-cycle pulse when ram_rddata is updated
- err  out  1  sticky; set on rden&wren in the same accept cycle
- sram_addr  out  ADDR_BITS+1  halfword address = {word addr, half}
- sram_dq_o  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_i  in  16  read data from pad
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM strobes

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - state IDLE; all sram_*_n = 1; sram_dq_oe = 0; sram_addr = 0; sram_dq_o = 0.
  - ram_rddata = 0; ram_busy = 0; ram_rdvalid = 0; err = 0.
  - Any in-flight access is abandoned with no partial completion signalled.
- States: IDLE, LO_ACC, LO_GAP, HI_ACC, HI_GAP, DONE.
- Accept (cycle T):
  - In IDLE with rden|wren=1, latch addr, wrdata, byteen and op (write if wren, else read), then go to LO_ACC.
  - If rden&wren both high, the request is a write and err is set (stays set until reset).
- LO_ACC and HI_ACC each last WAIT_CYCLES+1 cycles, counted by a 3-bit counter.
  - ce_n = 0 throughout.
  - Read: oe_n = 0, lb_n = ub_n = 0, dq_oe = 0.
  - Write: we_n = 0, dq_oe = 1, dq_o = selected halfword; lb_n = ~byteen[0]/~byteen[2] and ub_n = ~byteen[1]/~byteen[3] for the low/high half respectively.
  - A half with both enables clear still spends its cycles, with lb_n = ub_n = 1, so latency is fixed.
- Read capture: sram_dq_i is captured into the matching halfword of an internal buffer on the last ACC cycle.
- GAP states (1 cycle each):
  - ce_n, oe_n, we_n = 1.
  - Write data and dq_oe are held through the gap (hold time); sram_addr is unchanged.
  - sram_addr[0] changes only on entry to HI_ACC.
- DONE (1 cycle):
  - Read: ram_rddata <= buffer, ram_rdvalid = 1.
  - Write: no rdvalid, ram_rddata unchanged.
  - Next state IDLE.
- Timing:
  - ram_busy = 1 in every non-IDLE state, i.e. cycles T+1 .. T+2*(WAIT_CYCLES+2)+1.
  - Read latency accept -> rdvalid = 2*(WAIT_CYCLES+2)+1 cycles (7 at default).
- Back-to-back: a request still asserted in the IDLE cycle after DONE is accepted as a new request. Requesters deassert rden/wren on or before rdvalid / the busy falling edge.
- Requests arriving while busy are ignored, not queued.
- ram_rddata is held between reads.
- All strobe outputs are registered (glitch-free at pads).

Decomposition:
- Shared constants header: RAM_ADDR_BITS and RAM_ADDR_MAX (existing), plus new SRAM_WAIT_CYCLES default and the state encodings.
- No sub-module; the tristate pad (dq_o/dq_oe/dq_i) lives in the board top.

Test Plan:
- Write addr 5, data 32'hdead0005, byteen 4'hF, WAIT_CYCLES=1 -> halfword 10 = 16'h0005, halfword 11 = 16'hdead; we_n low exactly 2 cycles per half; busy high 7 cycles; no rdvalid.
- Read addr 5 after that write -> rdvalid pulse 7 cycles after accept, ram_rddata = 32'hdead0005, held until the next read.
- Write 32'h11223344 with byteen 4'b0100 over SRAM preloaded 0 -> only ub_n/lb_n for the high half asserted (lb_n=0, ub_n=1); subsequent read returns 32'h00220000.
- Hold rden and wren both high at accept, data 32'hcafef00d -> a write occurs, err = 1 and stays 1; a following read returns 32'hcafef00d.
- Assert rst during HI_ACC of a write -> the same cycle has we_n = 1, dq_oe = 0, busy = 0, rddata = 0, err = 0; the next request completes normally.
- Write/read sweep of all words 0..RAM_ADDR_MAX with data 32'hdead0000+addr, requests held until busy falls -> every read matches, err stays 0.
